// File: rtl/mem_sram_ctrl.sv
// mem_pkg request/response types and the SRAM endpoint that serves them.
// The endpoint zeroes the whole macro after reset, adds even parity per byte,
// flags out-of-range addresses and answers every grant in fixed latency.
package mem_pkg;
   localparam int MEM_AW = 32;
   localparam int MEM_DW = 32;

   typedef struct packed {
      logic              req;
      logic              we;
      logic [MEM_AW-1:0] addr;
      logic [MEM_DW-1:0] data;
      logic [MEM_DW/8-1:0] mask;
   } mem_h2d_t;

   typedef struct packed {
      logic              gnt;
      logic              valid;
      logic [MEM_DW-1:0] data;
      logic [1:0]        error;
   } mem_d2h_t;
endpackage

module mem_sram_ctrl
   import mem_pkg::*;
#(
   parameter int SRAM_AW    = 12,
   parameter int RD_LATENCY = 1,
   parameter int PARITY_EN  = 1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  mem_h2d_t                     mem_i,
   output mem_d2h_t                     mem_o,
   output logic                         init_done_o,
   output logic                         sram_req_o,
   output logic                         sram_we_o,
   output logic [SRAM_AW-1:0]           sram_addr_o,
   output logic [MEM_DW+MEM_DW/8-1:0]   sram_wdata_o,
   output logic [MEM_DW+MEM_DW/8-1:0]   sram_wmask_o,
   input  logic [MEM_DW+MEM_DW/8-1:0]   sram_rdata_i
);

   localparam int NB  = MEM_DW / 8;
   localparam int SW  = MEM_DW + NB;
   localparam int OFF = $clog2(NB);
   localparam int TOP = RD_LATENCY - 1;

   if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
      $error("mem_sram_ctrl: RD_LATENCY must be in 1..4");
   end

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   state_e               state_q, state_d;
   logic [SRAM_AW-1:0]   cnt_q, cnt_d;
   logic [RD_LATENCY-1:0] vld_q, we_q, oor_q;

   logic [SRAM_AW-1:0]   word;
   logic                 oor;
   logic                 gnt;
   logic [NB-1:0]        wpar;
   logic [NB-1:0]        rpar_err;
   logic [SW-1:0]        bytemask;
   logic                 unused_addr_lsb;

   assign word            = mem_i.addr[OFF+:SRAM_AW];
   assign oor             = |mem_i.addr[MEM_AW-1:OFF+SRAM_AW];
   assign unused_addr_lsb = ^mem_i.addr[OFF-1:0];
   assign init_done_o     = (state_q == ST_RUN);

   // Per-byte write parity, read parity check and byte-to-bit mask expansion.
   always_comb begin
      wpar     = '0;
      rpar_err = '0;
      bytemask = '0;
      for (int b = 0; b < NB; b++) begin
         wpar[b]            = (PARITY_EN != 0) ? ^mem_i.data[8*b+:8] : 1'b0;
         rpar_err[b]        = (PARITY_EN != 0) &&
                              ((^sram_rdata_i[8*b+:8]) != sram_rdata_i[MEM_DW+b]);
         bytemask[8*b+:8]   = {8{mem_i.mask[b]}};
         bytemask[MEM_DW+b] = mem_i.mask[b];
      end
   end

   // Sweep/run FSM: next state plus SRAM strobes. The sweep strobes are gated
   // by rst_ni so the macro sees nothing while reset is held.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      gnt          = 1'b0;
      sram_req_o   = 1'b0;
      sram_we_o    = 1'b0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      sram_wmask_o = '0;
      if (state_q == ST_INIT) begin
         sram_req_o   = rst_ni;
         sram_we_o    = rst_ni;
         sram_addr_o  = cnt_q;
         sram_wmask_o = {SW{rst_ni}};
         cnt_d        = cnt_q + 1'b1;
         if (cnt_q == '1) state_d = ST_RUN;
      end else begin
         gnt = mem_i.req;
         if (mem_i.req && !oor) begin
            sram_req_o   = 1'b1;
            sram_we_o    = mem_i.we;
            sram_addr_o  = word;
            sram_wdata_o = {wpar, mem_i.data};
            sram_wmask_o = mem_i.we ? bytemask : '0;
         end
      end
   end

   // FSM state and sweep address counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Response tags ride a shift register aligned with the SRAM read latency.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= '0;
         we_q  <= '0;
         oor_q <= '0;
      end else begin
         vld_q[0] <= gnt;
         we_q[0]  <= mem_i.we;
         oor_q[0] <= oor;
         for (int i = 1; i < RD_LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            we_q[i]  <= we_q[i-1];
            oor_q[i] <= oor_q[i-1];
         end
      end
   end

   // Response bus: data/error only while valid, zero otherwise.
   always_comb begin
      mem_o     = '0;
      mem_o.gnt = gnt;
      if (vld_q[TOP]) begin
         mem_o.valid = 1'b1;
         if (oor_q[TOP]) begin
            mem_o.error = 2'b10;
         end else if (!we_q[TOP]) begin
            mem_o.data  = sram_rdata_i[MEM_DW-1:0];
            mem_o.error = {|rpar_err, 1'b0};
         end
      end
   end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: SRAM macro model, word-level reference memory with
// a queue of expected responses checked every cycle, plus literal pins.
module tb_mem_sram_ctrl;
   import mem_pkg::*;

   localparam int AW    = 4;
   localparam int L     = 3;
   localparam int NB    = MEM_DW / 8;
   localparam int SW    = MEM_DW + NB;
   localparam int DEPTH = 2 ** AW;
   localparam int OFF   = 2;

   logic            clk_i = 1'b0;
   logic            rst_ni = 1'b0;
   mem_h2d_t        mem_i;
   mem_d2h_t        mem_o;
   logic            init_done_o, sram_req_o, sram_we_o;
   logic [AW-1:0]   sram_addr_o;
   logic [SW-1:0]   sram_wdata_o, sram_wmask_o, sram_rdata_i;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   mem_sram_ctrl #(.SRAM_AW(AW), .RD_LATENCY(L), .PARITY_EN(1)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .mem_i(mem_i), .mem_o(mem_o),
      .init_done_o(init_done_o), .sram_req_o(sram_req_o), .sram_we_o(sram_we_o),
      .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
      .sram_wmask_o(sram_wmask_o), .sram_rdata_i(sram_rdata_i)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc = cyc + 1;

   // ---------------- SRAM macro model (with parity-bit fault injection) -----
   logic          poke_en = 1'b0;
   int            poke_addr = 0;
   int            poke_bit = 0;
   logic [SW-1:0] sram [DEPTH];
   logic [SW-1:0] rd_pipe [L];

   always @(posedge clk_i) begin
      if (poke_en) sram[poke_addr][poke_bit] <= ~sram[poke_addr][poke_bit];
      else if (sram_req_o && sram_we_o)
         sram[sram_addr_o] <= (sram[sram_addr_o] & ~sram_wmask_o) | (sram_wdata_o & sram_wmask_o);
      rd_pipe[0] <= (sram_req_o && !sram_we_o) ? sram[sram_addr_o] : {SW{1'b1}};
      for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign sram_rdata_i = rd_pipe[L-1];

   // ---------------- hand-computed literal pins ----------------
   int          pin_due  [16];
   logic [31:0] pin_data [16];
   logic [1:0]  pin_err  [16];
   int          pin_n = 0;
   int          pin_idx = 0;
   int          pin_done = -100;

   // ---------------- reference model + per-cycle compare ----------------
   typedef struct {
      int          due;
      logic [31:0] data;
      logic [1:0]  err;
   } exp_t;

   exp_t          q[$];
   exp_t          e;
   logic [31:0]   ref_mem [DEPTH];
   logic [NB-1:0] bad [DEPTH];
   int            sweep = 0;
   bit            run = 0;
   int            w;
   bit            is_oor;
   logic [NB-1:0] par;
   logic [SW-1:0] emask;

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", n, cyc, act, exp);
      end
   endtask

   always @(negedge clk_i) begin
      if (!rst_ni) begin
         chk("rst_gnt", mem_o.gnt, 0);
         chk("rst_valid", mem_o.valid, 0);
         chk("rst_data", mem_o.data, 0);
         chk("rst_err", mem_o.error, 0);
         chk("rst_done", init_done_o, 0);
         chk("rst_sreq", sram_req_o, 0);
         chk("rst_swe", sram_we_o, 0);
         chk("rst_saddr", sram_addr_o, 0);
         chk("rst_wdata", sram_wdata_o, 0);
         chk("rst_wmask", sram_wmask_o, 0);
         sweep = 0;
         run = 0;
         q.delete();
         for (int k = 0; k < DEPTH; k++) begin
            ref_mem[k] = '0;
            bad[k] = '0;
         end
      end else begin
         if (cyc == pin_done)     chk("done_at_17", init_done_o, 1);
         if (cyc == pin_done - 1) chk("done_before", init_done_o, 0);

         if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("rsp_valid", mem_o.valid, 1);
            chk("rsp_data", mem_o.data, e.data);
            chk("rsp_err", mem_o.error, e.err);
         end else begin
            chk("idle_valid", mem_o.valid, 0);
            chk("idle_data", mem_o.data, 0);
            chk("idle_err", mem_o.error, 0);
         end

         if (pin_idx < pin_n && pin_due[pin_idx] == cyc) begin
            chk("pin_valid", mem_o.valid, 1);
            chk("pin_data", mem_o.data, pin_data[pin_idx]);
            chk("pin_err", mem_o.error, pin_err[pin_idx]);
            pin_idx++;
         end

         if (poke_en) bad[poke_addr][poke_bit-MEM_DW] = 1'b1;

         if (!run) begin
            chk("sweep_req", sram_req_o, 1);
            chk("sweep_we", sram_we_o, 1);
            chk("sweep_addr", sram_addr_o, sweep);
            chk("sweep_wdata", sram_wdata_o, 0);
            chk("sweep_wmask", sram_wmask_o, {SW{1'b1}});
            chk("sweep_gnt", mem_o.gnt, 0);
            chk("sweep_done", init_done_o, 0);
            sweep++;
            if (sweep == DEPTH) run = 1;
         end else begin
            chk("run_done", init_done_o, 1);
            chk("gnt", mem_o.gnt, mem_i.req);
            w = int'(mem_i.addr[OFF+:AW]);
            is_oor = (mem_i.addr >> (OFF + AW)) != 0;
            if (!mem_i.req) begin
               chk("no_req", sram_req_o, 0);
            end else if (is_oor) begin
               chk("oor_no_req", sram_req_o, 0);
               q.push_back('{cyc + L, 32'h0, 2'b10});
            end else begin
               chk("acc_req", sram_req_o, 1);
               chk("acc_we", sram_we_o, mem_i.we);
               chk("acc_addr", sram_addr_o, w);
               if (mem_i.we) begin
                  for (int b = 0; b < NB; b++) begin
                     par[b] = ^mem_i.data[8*b+:8];
                     emask[8*b+:8] = {8{mem_i.mask[b]}};
                     emask[MEM_DW+b] = mem_i.mask[b];
                     if (mem_i.mask[b]) begin
                        ref_mem[w][8*b+:8] = mem_i.data[8*b+:8];
                        bad[w][b] = 1'b0;
                     end
                  end
                  chk("wr_wdata", sram_wdata_o, {par, mem_i.data});
                  chk("wr_wmask", sram_wmask_o, emask);
                  q.push_back('{cyc + L, 32'h0, 2'b00});
               end else begin
                  chk("rd_wmask", sram_wmask_o, 0);
                  q.push_back('{cyc + L, ref_mem[w], (bad[w] != 0) ? 2'b10 : 2'b00});
               end
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      mem_i.req  = 1'b1;
      mem_i.we   = we;
      mem_i.addr = a;
      mem_i.data = d;
      mem_i.mask = m;
      step();
   endtask

   task automatic idle(input int n);
      mem_i = '0;
      repeat (n) step();
   endtask

   // Registers a literal response expected L cycles after the request about to be issued.
   task automatic pin(input logic [31:0] d, input logic [1:0] er);
      pin_due[pin_n]  = cyc + L;
      pin_data[pin_n] = d;
      pin_err[pin_n]  = er;
      pin_n++;
   endtask

   initial begin
      mem_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      pin_done = cyc + 16;
      idle(17);

      issue(1, 32'h8, 32'hA5A5_1234, 4'hF);
      pin(32'hA5A5_1234, 2'b00);
      issue(0, 32'h8, 32'h0, 4'h0);
      idle(4);

      issue(1, 32'h0, 32'hFFFF_FFFF, 4'b0010);
      pin(32'h0000_FF00, 2'b00);
      issue(0, 32'h0, 32'h0, 4'h0);
      idle(4);

      poke_en = 1'b1;
      poke_addr = 2;
      poke_bit = MEM_DW + 2;
      step();
      poke_en = 1'b0;
      pin(32'hA5A5_1234, 2'b10);
      issue(0, 32'h8, 32'h0, 4'h0);
      idle(4);

      pin(32'h0, 2'b10);
      issue(0, 32'h1 << (AW + 2), 32'h0, 4'h0);
      idle(4);

      issue(1, 32'h4,  32'h1122_3344, 4'hF);
      pin(32'h1122_3344, 2'b00);
      issue(0, 32'h4,  32'h0, 4'h0);
      issue(1, 32'hC,  32'hDEAD_BEEF, 4'b1001);
      pin(32'hDE00_00EF, 2'b00);
      issue(0, 32'hC,  32'h0, 4'h0);
      issue(1, 32'h3C, 32'h0102_0304, 4'hF);
      issue(0, 32'h3C, 32'h0, 4'h0);
      issue(0, 32'h80, 32'h0, 4'h0);
      issue(1, 32'h4,  32'hFFFF_FFFF, 4'b0100);
      mem_i = '0;
      rst_ni = 1'b0;
      step();
      step();
      rst_ni = 1'b1;
      pin_done = cyc + 16;
      idle(17);

      pin(32'h0, 2'b00);
      issue(0, 32'h4, 32'h0, 4'h0);
      idle(5);

      if (pin_idx != pin_n) begin
         failures++;
         $display("FAIL pins_consumed: got %0d expected %0d", pin_idx, pin_n);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
